// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one SRAM-like external bus between the instruction-fetch port and
// the data-access port. When a pipeline step requests both accesses, the data
// access runs first and the fetch follows. The whole pipeline stays frozen
// until every requested access has finished. It is then released for exactly
// one cycle (DONE), and the read data is valid in that cycle.
//
// Ports:
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   inst_en/inst_addr             fetch request for this pipeline step
//   inst_rdata                    fetched word, holds until the next fetch
//   data_en/data_wen/data_addr/   load/store request (data_wen == 0 is a load)
//   data_wdata
//   data_rdata                    load result, holds until the next data access
//   bus_req/bus_wen/bus_addr/     external request; only non-zero in *_ADDR states
//   bus_wdata
//   bus_addr_ok/bus_data_ok/      external handshake and read data
//   bus_rdata
//   stall_all                     freeze the pipeline (combinational)
//   bus_err                       one-cycle pulse, shown in DONE after a timeout abort
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_en,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    input  logic        data_en,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic [3:0]  bus_wen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        stall_all,
    output logic        bus_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_D_ADDR = 3'd1,
        ST_D_DATA = 3'd2,
        ST_I_ADDR = 3'd3,
        ST_I_DATA = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Counter value seen in the last allowed wait cycle. If no handshake
    // arrives in that cycle, the access is abandoned.
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t               state_r;
    state_t               state_s;
    logic [TIMEOUT_W-1:0] cnt_r;
    logic                 waiting_s;
    logic                 timeout_hit_s;
    logic                 latch_d_s;
    logic                 latch_i_s;
    logic                 abort_d_s;
    logic                 abort_i_s;

    assign timeout_hit_s = (cnt_r == TIMEOUT_LAST);

    // Next-state decode, bus request drive and stall generation.
    always_comb begin
        state_s   = state_r;
        stall_all = 1'b1;
        bus_req   = 1'b0;
        bus_wen   = 4'h0;
        bus_addr  = 32'h0;
        bus_wdata = 32'h0;
        waiting_s = 1'b0;
        latch_d_s = 1'b0;
        latch_i_s = 1'b0;
        abort_d_s = 1'b0;
        abort_i_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stall_all = inst_en | data_en;
                if (data_en) begin
                    state_s = ST_D_ADDR;
                end else if (inst_en) begin
                    state_s = ST_I_ADDR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_D_ADDR: begin
                bus_req   = 1'b1;
                bus_wen   = data_wen;
                bus_addr  = data_addr;
                bus_wdata = data_wdata;
                waiting_s = 1'b1;
                if (bus_addr_ok) begin
                    state_s = ST_D_DATA;
                end else if (timeout_hit_s) begin
                    abort_d_s = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    state_s = ST_D_ADDR;
                end
            end
            ST_D_DATA: begin
                waiting_s = 1'b1;
                if (bus_data_ok) begin
                    // Stores also capture whatever the bus returns.
                    latch_d_s = 1'b1;
                    state_s   = inst_en ? ST_I_ADDR : ST_DONE;
                end else if (timeout_hit_s) begin
                    abort_d_s = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    state_s = ST_D_DATA;
                end
            end
            ST_I_ADDR: begin
                bus_req   = 1'b1;
                bus_addr  = inst_addr;
                waiting_s = 1'b1;
                if (bus_addr_ok) begin
                    state_s = ST_I_DATA;
                end else if (timeout_hit_s) begin
                    abort_i_s = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    state_s = ST_I_ADDR;
                end
            end
            ST_I_DATA: begin
                waiting_s = 1'b1;
                if (bus_data_ok) begin
                    latch_i_s = 1'b1;
                    state_s   = ST_DONE;
                end else if (timeout_hit_s) begin
                    abort_i_s = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    state_s = ST_I_DATA;
                end
            end
            ST_DONE: begin
                stall_all = 1'b0;
                state_s   = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and wait-cycle counter. The counter restarts on every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {TIMEOUT_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (state_s != state_r) begin
                cnt_r <= {TIMEOUT_W{1'b0}};
            end else if (waiting_s) begin
                cnt_r <= cnt_r + TIMEOUT_W'(1);
            end else begin
                cnt_r <= {TIMEOUT_W{1'b0}};
            end
        end
    end

    // Read-data capture. An aborted access zeroes its register; a port that was not requested keeps its old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_rdata <= 32'h0;
            data_rdata <= 32'h0;
            bus_err    <= 1'b0;
        end else begin
            bus_err <= abort_d_s | abort_i_s;
            if (latch_d_s) begin
                data_rdata <= bus_rdata;
            end else if (abort_d_s) begin
                data_rdata <= 32'h0;
            end else begin
                data_rdata <= data_rdata;
            end
            if (latch_i_s) begin
                inst_rdata <= bus_rdata;
            end else if (abort_i_s) begin
                inst_rdata <= 32'h0;
            end else begin
                inst_rdata <= inst_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter. The stimulus drives the bus handshake
// cycle by cycle and pushes the expected results into two queues. One queue
// holds the request beats; the other holds the step results. The monitor
// samples the outputs on the falling edge, pops an entry for every bus_req
// beat and for every falling edge of stall_all (the release cycle), and
// compares it with the outputs.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        data_en;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        bus_req;
    logic [3:0]  bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        stall_all;
    logic        bus_err;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
        .clk(clk), .rst(rst),
        .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .stall_all(stall_all), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] data;
        logic        err;
        int          stall;
        int          req;
    } done_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } beat_t;

    done_t exp_done[$];
    beat_t exp_beat[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;
    bit prev_stall = 1'b0;
    int stall_cnt = 0;
    int req_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_done(input logic [31:0] inst, input logic [31:0] data,
                             input logic err, input int stall, input int req);
        done_t d;
        d.inst = inst; d.data = data; d.err = err; d.stall = stall; d.req = req;
        exp_done.push_back(d);
    endtask

    task automatic push_beat(input logic [31:0] addr, input logic [3:0] wen,
                             input logic [31:0] wdata, input int n);
        beat_t b;
        b.addr = addr; b.wen = wen; b.wdata = wdata;
        for (int i = 0; i < n; i++) exp_beat.push_back(b);
    endtask

    // Drive the bus response for one cycle, then advance to just after the next rising edge.
    task automatic step(input logic aok, input logic dok, input logic [31:0] rd);
        bus_addr_ok = aok;
        bus_data_ok = dok;
        bus_rdata   = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        inst_en = 1'b0; inst_addr = 32'h0;
        data_en = 1'b0; data_wen = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    endtask

    // Monitor: check each bus beat, and each release of the pipeline.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_req) begin
                req_cnt++;
                if (exp_beat.size() == 0) begin
                    chk("beat_unexpected", 32'h1, 32'h0);
                end else begin
                    beat_t b;
                    b = exp_beat.pop_front();
                    chk("bus_addr", bus_addr, b.addr);
                    chk("bus_wen", {28'h0, bus_wen}, {28'h0, b.wen});
                    chk("bus_wdata", bus_wdata, b.wdata);
                end
            end
            if (bus_err && !(prev_stall && !stall_all)) begin
                chk("bus_err_stray", {31'h0, bus_err}, 32'h0);
            end
            if (stall_all) begin
                stall_cnt++;
            end else if (prev_stall) begin
                if (exp_done.size() == 0) begin
                    chk("done_unexpected", 32'h1, 32'h0);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    chk("inst_rdata", inst_rdata, d.inst);
                    chk("data_rdata", data_rdata, d.data);
                    chk("bus_err", {31'h0, bus_err}, {31'h0, d.err});
                    chk("stall_cycles", 32'(stall_cnt), 32'(d.stall));
                    chk("req_cycles", 32'(req_cnt), 32'(d.req));
                end
                stall_cnt = 0;
                req_cnt   = 0;
            end
            prev_stall = stall_all;
        end
    end

    initial begin
        rst = 1'b1;
        clear_req();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state
        chk("rst_stall", {31'h0, stall_all}, 32'h0);
        chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
        chk("rst_bus_wen", {28'h0, bus_wen}, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        chk("rst_inst_rdata", inst_rdata, 32'h0);
        chk("rst_data_rdata", data_rdata, 32'h0);
        inst_en = 1'b1; #1;
        chk("rst_stall_idle_eq", {31'h0, stall_all}, 32'h1);
        inst_en = 1'b0; #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // 1: single fetch, immediate handshakes
        inst_en = 1'b1; inst_addr = 32'hBFC00000;
        push_beat(32'hBFC00000, 4'h0, 32'h0, 1);
        push_done(32'h3C1D0001, 32'h0, 1'b0, 3, 1);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h3C1D0001);
        clear_req();
        step(1'b0, 1'b0, 32'h0);

        // 2: load + fetch, data first
        inst_en = 1'b1; inst_addr = 32'hBFC00004;
        data_en = 1'b1; data_wen = 4'h0; data_addr = 32'h80001000;
        push_beat(32'h80001000, 4'h0, 32'h0, 1);
        push_beat(32'hBFC00004, 4'h0, 32'h0, 1);
        push_done(32'h22222222, 32'h11111111, 1'b0, 5, 2);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h11111111);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h22222222);
        clear_req();
        step(1'b0, 1'b0, 32'h0);

        // 3: store, addr_ok delayed 3 cycles; request held for 4 cycles
        data_en = 1'b1; data_wen = 4'b0011; data_addr = 32'h80002000; data_wdata = 32'hDEADBEEF;
        push_beat(32'h80002000, 4'b0011, 32'hDEADBEEF, 4);
        push_done(32'h22222222, 32'hCAFEF00D, 1'b0, 6, 4);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hCAFEF00D);
        clear_req();
        step(1'b0, 1'b0, 32'h0);

        // 4: spurious data_ok while in D_ADDR is ignored
        data_en = 1'b1; data_addr = 32'h80003000;
        push_beat(32'h80003000, 4'h0, 32'h0, 2);
        push_done(32'h22222222, 32'h12345678, 1'b0, 5, 2);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h99999999);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h12345678);
        clear_req();
        step(1'b0, 1'b0, 32'h0);

        // 5: data_ok never arrives -> timeout after 4 wait cycles in D_DATA
        data_en = 1'b1; data_addr = 32'h80004000;
        push_beat(32'h80004000, 4'h0, 32'h0, 1);
        push_done(32'h22222222, 32'h0, 1'b1, 6, 1);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
        clear_req();
        step(1'b0, 1'b0, 32'h0);

        // 6: fetch addr_ok never arrives -> timeout in I_ADDR, inst_rdata zeroed
        inst_en = 1'b1; inst_addr = 32'hBFC00008;
        push_beat(32'hBFC00008, 4'h0, 32'h0, 4);
        push_done(32'h0, 32'h0, 1'b1, 5, 4);
        step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
        clear_req();
        step(1'b0, 1'b0, 32'h0);

        // 7: load + fetch success, leaving both registers non-zero
        inst_en = 1'b1; inst_addr = 32'hBFC0000C;
        data_en = 1'b1; data_addr = 32'h80006000; data_wdata = 32'h0BADF00D;
        push_beat(32'h80006000, 4'h0, 32'h0BADF00D, 1);
        push_beat(32'hBFC0000C, 4'h0, 32'h0, 1);
        push_done(32'h5555AAAA, 32'hAAAA5555, 1'b0, 5, 2);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hAAAA5555);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h5555AAAA);
        clear_req();
        step(1'b0, 1'b0, 32'h0);

        // 8: reset during I_DATA; a late data_ok is ignored
        inst_en = 1'b1; inst_addr = 32'hBFC00010;
        push_beat(32'hBFC00010, 4'h0, 32'h0, 1);
        push_done(32'h0, 32'h0, 1'b0, 3, 1);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        rst = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        clear_req();
        step(1'b0, 1'b1, 32'hFFFFFFFF);
        step(1'b0, 1'b1, 32'hFFFFFFFF);
        step(1'b0, 1'b0, 32'h0);
        chk("post_rst_inst_rdata", inst_rdata, 32'h0);
        chk("post_rst_data_rdata", data_rdata, 32'h0);
        chk("post_rst_stall", {31'h0, stall_all}, 32'h0);

        chk("done_queue_empty", 32'(exp_done.size()), 32'h0);
        chk("beat_queue_empty", 32'(exp_beat.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
